// File: rtl/riscv_config_pkg.sv
// Core-wide configuration constants shared by the fetch-side predictor.
package riscv_config_pkg;

    localparam int unsigned ADDR_WIDTH          = 32;
    localparam int unsigned BTB_ENTRIES_DEFAULT = 64;

endpackage

// File: rtl/riscv_types_pkg.sv
// Shared types for the fetch/execute interface and the BTB entry format.
package riscv_types_pkg;

    import riscv_config_pkg::*;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    // Direction counter encoding.
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    typedef struct packed {
        logic  predict_taken;
        addr_t predict_target;
        logic  btb_hit;
    } branch_prediction_t;

    typedef struct packed {
        logic  update_valid;
        addr_t update_pc;
        logic  actual_taken;
        addr_t actual_target;
        logic  is_branch;
    } branch_update_t;

    // The tag field is held at full address width so the entry type does not
    // depend on the table size; the unused high bits are always zero.
    typedef struct packed {
        logic       valid;
        addr_t      tag;
        addr_t      target;
        logic [1:0] ctr;
    } btb_entry_t;

    // 2-bit saturating counter step toward the observed direction.
    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_STRONG_T) ? CTR_STRONG_T : ctr + 2'd1;
        end
        return (ctr == CTR_STRONG_NT) ? CTR_STRONG_NT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit direction counter per entry. Lookup is
// combinational from the flop array; training writes at most one entry per cycle.
module branch_predictor
    import riscv_config_pkg::*;
    import riscv_types_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
    parameter int unsigned IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               lookup_valid_i,
    input  addr_t              lookup_pc_i,
    output branch_prediction_t prediction_o,
    input  branch_update_t     update_i
);

    btb_entry_t [BTB_ENTRIES-1:0] btb_q;

    logic [IDX_W-1:0] lk_idx;
    addr_t            lk_tag;
    btb_entry_t       lk_entry;
    logic             lk_hit;

    logic [IDX_W-1:0] upd_idx;
    addr_t            upd_tag;
    btb_entry_t       upd_entry;
    logic             upd_hit;
    logic             wr_en;
    btb_entry_t       wr_entry;

    // Byte-offset bits of the update PC carry no information for a word-aligned BTB.
    logic [1:0] unused_upd_pc_lsb;
    assign unused_upd_pc_lsb = update_i.update_pc[1:0];

    // Lookup: read the indexed entry and form the prediction.
    always_comb begin
        lk_idx   = lookup_pc_i[IDX_W+1:2];
        lk_tag   = lookup_pc_i >> (IDX_W + 2);
        lk_entry = btb_q[lk_idx];
        lk_hit   = lookup_valid_i && lk_entry.valid && (lk_entry.tag == lk_tag);

        prediction_o = '0;
        if (lookup_valid_i) begin
            prediction_o.btb_hit        = lk_hit;
            prediction_o.predict_taken  = lk_hit && lk_entry.ctr[1];
            prediction_o.predict_target = lk_hit ? lk_entry.target
                                                 : lookup_pc_i + ADDR_WIDTH'(4);
        end
    end

    // Training: decide whether and what to write at the update index.
    always_comb begin
        upd_idx   = update_i.update_pc[IDX_W+1:2];
        upd_tag   = update_i.update_pc >> (IDX_W + 2);
        upd_entry = btb_q[upd_idx];
        upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

        wr_en    = 1'b0;
        wr_entry = upd_entry;

        if (update_i.update_valid) begin
            if (update_i.is_branch) begin
                if (upd_hit) begin
                    wr_en        = 1'b1;
                    wr_entry.ctr = sat_ctr_next(upd_entry.ctr, update_i.actual_taken);
                    if (update_i.actual_taken) begin
                        wr_entry.target = update_i.actual_target;
                    end
                end else if (update_i.actual_taken) begin
                    // Taken miss allocates, evicting any alias at this index.
                    wr_en           = 1'b1;
                    wr_entry.valid  = 1'b1;
                    wr_entry.tag    = upd_tag;
                    wr_entry.target = update_i.actual_target;
                    wr_entry.ctr    = CTR_WEAK_T;
                end
            end else begin
                // Jumps always go taken, so they start strongly biased.
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = upd_tag;
                wr_entry.target = update_i.actual_target;
                wr_entry.ctr    = CTR_STRONG_T;
            end
        end
    end

    // Array state: reset clears only valid bits; updates during reset are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            btb_q[upd_idx] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run against a table-level reference model.
module tb_branch_predictor;

    import riscv_config_pkg::*;
    import riscv_types_pkg::*;

    localparam int NENT = 64;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               lookup_valid_i;
    addr_t              lookup_pc_i;
    branch_prediction_t prediction_o;
    branch_update_t     update_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one slot per index, counter kept as a bounded integer.
    bit          m_valid [NENT];
    logic [31:0] m_tag   [NENT];
    logic [31:0] m_target[NENT];
    int          m_ctr   [NENT];

    branch_predictor dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_pc_i    (lookup_pc_i),
        .prediction_o   (prediction_o),
        .update_i       (update_i)
    );

    always #5 clk = ~clk;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / (4 * NENT);
    endfunction

    function automatic branch_prediction_t model_predict(input bit v, input logic [31:0] pc);
        branch_prediction_t p;
        int  i;
        bit  hit;
        p = '0;
        if (!v) return p;
        i   = m_idx(pc);
        hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
        p.btb_hit        = hit;
        p.predict_taken  = hit && (m_ctr[i] >= 2);
        p.predict_target = hit ? m_target[i] : pc + 32'd4;
        return p;
    endfunction

    task automatic model_update(input branch_update_t u);
        int i;
        bit hit;
        if (!u.update_valid) return;
        i   = m_idx(u.update_pc);
        hit = m_valid[i] && (m_tag[i] == m_tagof(u.update_pc));
        if (u.is_branch && hit) begin
            if (u.actual_taken) begin
                if (m_ctr[i] < 3) m_ctr[i]++;
                m_target[i] = u.actual_target;
            end else if (m_ctr[i] > 0) begin
                m_ctr[i]--;
            end
        end else if (!u.is_branch || u.actual_taken) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = m_tagof(u.update_pc);
            m_target[i] = u.actual_target;
            m_ctr[i]    = u.is_branch ? 2 : 3;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk);
        model_reset();
        #1 rst_i = 1'b0;
    endtask

    // One training record across one clock edge.
    task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                         input bit is_br);
        update_i = '{update_valid: 1'b1, update_pc: pc, actual_taken: taken,
                     actual_target: tgt, is_branch: is_br};
        @(posedge clk);
        model_update(update_i);
        #1 update_i = '0;
    endtask

    task automatic look(input bit v, input logic [31:0] pc);
        lookup_valid_i = v;
        lookup_pc_i    = pc;
        #1;
    endtask

    function automatic branch_prediction_t mk(input bit tk, input logic [31:0] tg, input bit h);
        branch_prediction_t p;
        p.predict_taken  = tk;
        p.predict_target = tg;
        p.btb_hit        = h;
        return p;
    endfunction

    task automatic test_reset();
        logic [31:0] pc;
        branch_prediction_t exp;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pc = $urandom;
            look(1'b1, pc);
            exp = mk(1'b0, pc + 32'd4, 1'b0);
            n_cmp++;
            if (prediction_o !== exp) begin
                n_err++;
                $display("FAIL reset_lookup pc=%h got=%h exp=%h", pc, prediction_o, exp);
            end
        end
    endtask

    task automatic test_cold_lookup();
        look(1'b1, 32'h100);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h104, 1'b0)) begin
            n_err++;
            $display("FAIL cold_lookup got=%h exp=%h", prediction_o, mk(1'b0, 32'h104, 1'b0));
        end
        look(1'b0, 32'h100);
        n_cmp++;
        if (prediction_o !== '0) begin
            n_err++;
            $display("FAIL cold_invalid got=%h exp=0", prediction_o);
        end
    endtask

    task automatic test_allocate_weaken();
        train(32'h100, 1'b1, 32'h200, 1'b1);
        look(1'b1, 32'h100);
        n_cmp++;
        if (prediction_o !== mk(1'b1, 32'h200, 1'b1)) begin
            n_err++;
            $display("FAIL alloc_hit got=%h exp=%h", prediction_o, mk(1'b1, 32'h200, 1'b1));
        end
        train(32'h100, 1'b0, 32'h0, 1'b1);
        look(1'b1, 32'h100);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h200, 1'b1)) begin
            n_err++;
            $display("FAIL weak_nt got=%h exp=%h", prediction_o, mk(1'b0, 32'h200, 1'b1));
        end
        train(32'h100, 1'b0, 32'h0, 1'b1);
        look(1'b1, 32'h100);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h200, 1'b1)) begin
            n_err++;
            $display("FAIL strong_nt got=%h exp=%h", prediction_o, mk(1'b0, 32'h200, 1'b1));
        end
    endtask

    task automatic test_saturation();
        do_reset();
        train(32'h100, 1'b1, 32'h200, 1'b1);
        for (int k = 0; k < 3; k++) train(32'h100, 1'b1, 32'h200, 1'b1);
        train(32'h100, 1'b0, 32'h0, 1'b1);
        look(1'b1, 32'h100);
        n_cmp++;
        if (prediction_o !== mk(1'b1, 32'h200, 1'b1)) begin
            n_err++;
            $display("FAIL sat_high got=%h exp=%h", prediction_o, mk(1'b1, 32'h200, 1'b1));
        end
        train(32'h100, 1'b0, 32'h0, 1'b1);
        look(1'b1, 32'h100);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h200, 1'b1)) begin
            n_err++;
            $display("FAIL sat_step_down got=%h exp=%h", prediction_o, mk(1'b0, 32'h200, 1'b1));
        end
        train(32'h340, 1'b0, 32'h500, 1'b1);
        look(1'b1, 32'h340);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h344, 1'b0)) begin
            n_err++;
            $display("FAIL nt_miss_noalloc got=%h exp=%h", prediction_o, mk(1'b0, 32'h344, 1'b0));
        end
    endtask

    task automatic test_aliasing();
        do_reset();
        train(32'h100, 1'b1, 32'h200, 1'b1);
        look(1'b1, 32'h200);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h204, 1'b0)) begin
            n_err++;
            $display("FAIL alias_miss got=%h exp=%h", prediction_o, mk(1'b0, 32'h204, 1'b0));
        end
        train(32'h200, 1'b0, 32'h300, 1'b0);
        look(1'b1, 32'h200);
        n_cmp++;
        if (prediction_o !== mk(1'b1, 32'h300, 1'b1)) begin
            n_err++;
            $display("FAIL jump_alloc got=%h exp=%h", prediction_o, mk(1'b1, 32'h300, 1'b1));
        end
        look(1'b1, 32'h100);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h104, 1'b0)) begin
            n_err++;
            $display("FAIL alias_evict got=%h exp=%h", prediction_o, mk(1'b0, 32'h104, 1'b0));
        end
        // A jump starts strong: one not-taken branch update still predicts taken.
        train(32'h200, 1'b0, 32'h0, 1'b1);
        look(1'b1, 32'h200);
        n_cmp++;
        if (prediction_o !== mk(1'b1, 32'h300, 1'b1)) begin
            n_err++;
            $display("FAIL jump_strong got=%h exp=%h", prediction_o, mk(1'b1, 32'h300, 1'b1));
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        update_i = '{update_valid: 1'b1, update_pc: 32'h100, actual_taken: 1'b1,
                     actual_target: 32'h200, is_branch: 1'b1};
        look(1'b1, 32'h100);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h104, 1'b0)) begin
            n_err++;
            $display("FAIL hazard_pre got=%h exp=%h", prediction_o, mk(1'b0, 32'h104, 1'b0));
        end
        @(posedge clk);
        model_update(update_i);
        #1 update_i = '0;
        n_cmp++;
        if (prediction_o !== mk(1'b1, 32'h200, 1'b1)) begin
            n_err++;
            $display("FAIL hazard_post got=%h exp=%h", prediction_o, mk(1'b1, 32'h200, 1'b1));
        end
    endtask

    task automatic test_reset_mid();
        train(32'h104, 1'b0, 32'h400, 1'b0);
        rst_i    = 1'b1;
        update_i = '{update_valid: 1'b1, update_pc: 32'h180, actual_taken: 1'b1,
                     actual_target: 32'h600, is_branch: 1'b0};
        @(posedge clk);
        model_reset();
        #1;
        rst_i    = 1'b0;
        update_i = '0;
        look(1'b1, 32'h100);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h104, 1'b0)) begin
            n_err++;
            $display("FAIL rst_clear_a got=%h exp=%h", prediction_o, mk(1'b0, 32'h104, 1'b0));
        end
        look(1'b1, 32'h104);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h108, 1'b0)) begin
            n_err++;
            $display("FAIL rst_clear_b got=%h exp=%h", prediction_o, mk(1'b0, 32'h108, 1'b0));
        end
        look(1'b1, 32'h180);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h184, 1'b0)) begin
            n_err++;
            $display("FAIL rst_drop_update got=%h exp=%h", prediction_o, mk(1'b0, 32'h184, 1'b0));
        end
        look(1'b1, 32'hFFFF_FFFC);
        n_cmp++;
        if (prediction_o !== mk(1'b0, 32'h0, 1'b0)) begin
            n_err++;
            $display("FAIL wrap_target got=%h exp=%h", prediction_o, mk(1'b0, 32'h0, 1'b0));
        end
    endtask

    // Small PC pool so hits, aliases and counter saturation all occur often.
    function automatic logic [31:0] rand_pc();
        return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    endfunction

    task automatic test_random();
        branch_prediction_t exp;
        bit do_rst;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            do_rst   = ($urandom_range(0, 49) == 0);
            rst_i    = do_rst;
            update_i = '{update_valid: ($urandom_range(0, 3) != 0), update_pc: rand_pc(),
                         actual_taken: $urandom_range(0, 1), actual_target: $urandom,
                         is_branch: ($urandom_range(0, 4) != 0)};
            look($urandom_range(0, 7) != 0, rand_pc());
            exp = model_predict(lookup_valid_i, lookup_pc_i);
            n_cmp++;
            if (prediction_o !== exp) begin
                n_err++;
                $display("FAIL random[%0d] pc=%h got=%h exp=%h", k, lookup_pc_i, prediction_o, exp);
            end
            @(posedge clk);
            if (do_rst) model_reset();
            else        model_update(update_i);
            #1;
            rst_i    = 1'b0;
            update_i = '0;
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        lookup_valid_i = 1'b0;
        lookup_pc_i    = '0;
        update_i       = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_cold_lookup();
        test_allocate_weaken();
        test_saturation();
        test_aliasing();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
